// File: rtl/t08_dencode.sv
// Registered 4-bit code checker: odd parity (selector=0) or one-hot validity (selector=1).
// One output flop; synchronous active-high reset clears the flag.
module t08_dencode #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] masukan,
  input  logic             selector,
  output logic             keluaran
);

  logic       parity_d;
  logic       one_hot_d;
  logic [1:0] ones_cnt;
  logic       keluaran_d;
  logic       keluaran_q;

  always_comb begin
    parity_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      parity_d = parity_d ^ masukan[i];
    end
  end

  // Set-bit count saturates at 2: only "zero", "one" and "more than one" matter.
  always_comb begin
    ones_cnt = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (masukan[i] && (ones_cnt != 2'd2)) begin
        ones_cnt = ones_cnt + 2'd1;
      end
    end
    one_hot_d = (ones_cnt == 2'd1);
  end

  always_comb begin
    keluaran_d = selector ? one_hot_d : parity_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keluaran_q <= 1'b0;
    end else begin
      keluaran_q <= keluaran_d;
    end
  end

  assign keluaran = keluaran_q;

endmodule

// File: tb/tb_t08_dencode.sv
// Self-checking bench for t08_dencode: directed table, exhaustive sweep with
// mid-stream reset, reset-is-synchronous check and randomized model comparison.
module tb_t08_dencode;

  logic       clk;
  logic       rst;
  logic [3:0] masukan;
  logic       selector;
  logic       keluaran;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       r;
    logic [3:0] m;
    logic       s;
    logic       exp;
  } vec_t;

  vec_t vecs[20];

  t08_dencode #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .masukan  (masukan),
    .selector (selector),
    .keluaran (keluaran)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flag derived from the number of set bits.
  function automatic logic model(input logic r, input logic [3:0] m, input logic s);
    int ones;
    ones = $countones(m);
    if (r) return 1'b0;
    if (s) return (ones == 1);
    return ((ones % 2) == 1);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: keluaran=%b expected=%b (rst=%b masukan=%b selector=%b)",
               name, act, exp, rst, masukan, selector);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [3:0] m, input logic s);
    rst      = r;
    masukan  = m;
    selector = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] iv;
    logic       r, s, exp;
    logic [3:0] m;

    rst = 1'b1;
    masukan = 4'b0000;
    selector = 1'b0;

    vecs = '{
      '{1'b1, 4'b0001, 1'b1, 1'b0},
      '{1'b1, 4'b0001, 1'b1, 1'b0},
      '{1'b0, 4'b0001, 1'b1, 1'b1},
      '{1'b0, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 4'b1011, 1'b0, 1'b1},
      '{1'b0, 4'b1111, 1'b0, 1'b0},
      '{1'b0, 4'b0100, 1'b0, 1'b1},
      '{1'b0, 4'b0001, 1'b1, 1'b1},
      '{1'b0, 4'b0010, 1'b1, 1'b1},
      '{1'b0, 4'b0100, 1'b1, 1'b1},
      '{1'b0, 4'b1000, 1'b1, 1'b1},
      '{1'b0, 4'b0000, 1'b1, 1'b0},
      '{1'b0, 4'b0110, 1'b1, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 1'b0},
      '{1'b0, 4'b0011, 1'b0, 1'b0},
      '{1'b0, 4'b0011, 1'b1, 1'b0},
      '{1'b0, 4'b0011, 1'b0, 1'b0},
      '{1'b0, 4'b1000, 1'b0, 1'b1},
      '{1'b0, 4'b1000, 1'b1, 1'b1},
      '{1'b0, 4'b1000, 1'b0, 1'b1}
    };

    for (int k = 0; k < 20; k++) begin
      step(vecs[k].r, vecs[k].m, vecs[k].s);
      check($sformatf("table[%0d]", k), keluaran, vecs[k].exp);
    end

    // Output is 1 here; raising rst between edges must not clear it.
    rst = 1'b1;
    #2;
    check("rst_no_async", keluaran, 1'b1);
    @(posedge clk);
    #1;
    check("rst_sync_clear", keluaran, 1'b0);

    for (int i = 0; i < 32; i++) begin
      iv = 5'(i);
      m = iv[4:1];
      s = iv[0];
      r = (i == 13);
      step(r, m, s);
      check($sformatf("sweep[%0d]", i), keluaran, model(r, m, s));
      if (i == 14) check("sweep_after_rst", keluaran, 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 9) == 0);
      m = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      exp = model(r, m, s);
      step(r, m, s);
      check($sformatf("rand[%0d]", i), keluaran, exp);
    end

    // Holding inputs steady holds the output.
    step(1'b0, 4'b0111, 1'b0);
    step(1'b0, 4'b0111, 1'b0);
    check("hold", keluaran, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
